// File: rtl/logic_bist_ctrl_if.sv
// logic_bist_ctrl_if: control/status handshake plus the pins of the function under test.
// The master is the test controller that also owns the function under test; the slave is the sequencer.
interface logic_bist_ctrl_if #(
  parameter int N_IN = 3
);
  localparam int V = 1 << N_IN;
  logic          start;
  logic          abort;
  logic [N_IN-1:0] dut_in;
  logic          dut_x;
  logic          dut_y;
  logic          busy;
  logic          done;
  logic          pass;
  logic [V-1:0]  cap_x;
  logic [V-1:0]  cap_y;
  logic [V-1:0]  fail_mask_x;
  logic [V-1:0]  fail_mask_y;
  modport master (
    output start, abort, dut_x, dut_y,
    input  dut_in, busy, done, pass, cap_x, cap_y, fail_mask_x, fail_mask_y
  );
  modport slave (
    input  start, abort, dut_x, dut_y,
    output dut_in, busy, done, pass, cap_x, cap_y, fail_mask_x, fail_mask_y
  );
endinterface

// File: rtl/logic_bist_ctrl.sv
// logic_bist_ctrl: exhaustive ascending sweep of a 2-output function, capturing its truth tables
// and comparing them against expected tables to produce pass and per-vector fail masks.
module logic_bist_ctrl #(
  parameter int N_IN = 3,
  parameter int SETTLE_CYCLES = 1,
  parameter logic [(1<<N_IN)-1:0] EXP_X = 8'h6A,
  parameter logic [(1<<N_IN)-1:0] EXP_Y = 8'hD3
) (
  input logic clk,
  input logic rst_n,
  logic_bist_ctrl_if.slave bus
);
  localparam int V = 1 << N_IN;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t state, state_n;
  logic [N_IN-1:0] vec, vec_n;
  logic [3:0] cnt, cnt_n;
  logic busy, busy_n, done, done_n, pass, pass_n;
  logic [V-1:0] cap_x, cap_x_n, cap_y, cap_y_n;
  logic [V-1:0] mask_x, mask_x_n, mask_y, mask_y_n;
  always_comb begin
    state_n  = state;
    vec_n    = vec;
    cnt_n    = cnt;
    busy_n   = busy;
    done_n   = 1'b0;
    pass_n   = pass;
    cap_x_n  = cap_x;
    cap_y_n  = cap_y;
    mask_x_n = mask_x;
    mask_y_n = mask_y;
    // abort outranks everything outside IDLE, including the capture of a SAMPLE cycle
    if (state != IDLE && bus.abort) begin
      state_n = IDLE;
      vec_n   = '0;
      busy_n  = 1'b0;
      pass_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start && !bus.abort) begin
          state_n  = SETTLE;
          vec_n    = '0;
          cnt_n    = '0;
          busy_n   = 1'b1;
          pass_n   = 1'b0;
          cap_x_n  = '0;
          cap_y_n  = '0;
          mask_x_n = '0;
          mask_y_n = '0;
        end
        SETTLE: begin
          cnt_n   = cnt + 4'd1;
          state_n = (cnt == SETTLE_LAST) ? SAMPLE : SETTLE;
        end
        SAMPLE: begin
          cap_x_n[vec] = bus.dut_x;
          cap_y_n[vec] = bus.dut_y;
          state_n = (vec == '1) ? DONE : SETTLE;
          vec_n   = (vec == '1) ? vec : vec + 1'b1;
          cnt_n   = '0;
        end
        DONE: begin
          mask_x_n = cap_x ^ EXP_X;
          mask_y_n = cap_y ^ EXP_Y;
          pass_n   = (cap_x == EXP_X) && (cap_y == EXP_Y);
          done_n   = 1'b1;
          busy_n   = 1'b0;
          vec_n    = '0;
          state_n  = IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      vec    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
      cap_x  <= '0;
      cap_y  <= '0;
      mask_x <= '0;
      mask_y <= '0;
    end else begin
      state  <= state_n;
      vec    <= vec_n;
      cnt    <= cnt_n;
      busy   <= busy_n;
      done   <= done_n;
      pass   <= pass_n;
      cap_x  <= cap_x_n;
      cap_y  <= cap_y_n;
      mask_x <= mask_x_n;
      mask_y <= mask_y_n;
    end
  end
  assign bus.dut_in      = vec;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.pass        = pass;
  assign bus.cap_x       = cap_x;
  assign bus.cap_y       = cap_y;
  assign bus.fail_mask_x = mask_x;
  assign bus.fail_mask_y = mask_y;
endmodule
